multi_row_serializer: RTL and testbench
=======================================

// Module: multi_row_serializer
// PURPOSE
//  Inverse of the vertical line-window buffer. Accepts one beat per column carrying BufferRows stacked
//  pixels per channel (row 0 = newest line, row BufferRows-1 = oldest line).
//  Re-emits them as a single-pixel raster stream, oldest line first.
//  Sits after column-oriented stages (vertical filters, debug taps) to restore raster order for output or DMA.
// PARAMETERS
//  BufferWidth    8  bits per pixel per channel
//  LineWidth      8  columns per line (beats per row group); must be >= 2
//  BufferRows     2  stacked rows per input beat; 1 => pure pass-through, no RAM instantiated
//  InputChannels  1  parallel channels, serialized together (one pixel per channel per output beat)
// PORTS
//  clk_i    in   1                                    single clock, all logic rising-edge
//  rst_ni   in   1                                    asynchronous, active-low reset
//  data_i   in   [InputChannels][BufferRows][BufferWidth]  stacked column, [ch][r]
//  valid_i  in   1                                    input beat valid
//  ready_o  out  1                                    input beat accepted when valid_i && ready_o
//  data_o   out  [InputChannels][BufferWidth]         one pixel per channel, raster order
//  valid_o  out  1                                    output beat valid
//  ready_i  in   1                                    downstream accept
//  row_o    out  $clog2(BufferRows)+1                 index r of row currently emitted
//  last_o   out  1                                    high on final column (col == LineWidth-1) of each emitted row
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=PASS, col=0, row=BufferRows-1, replay output register empty;
//   ready_o=0, valid_o=0, last_o=0, row_o=BufferRows-1, data_o=0 while reset asserted.
//  State PASS (emit oldest row live, zero latency):
//   - data_o = data_i[ch][BufferRows-1]; valid_o = valid_i; ready_o = ready_i; row_o = BufferRows-1.
//   - On in_fire: write rows BufferRows-2..0 of all channels to RAM at address col; col++.
//   - last_o = valid_o && col==LineWidth-1.
//   - On the in_fire with col==LineWidth-1: col->0, row->BufferRows-2, go REPLAY (BufferRows=1: stay PASS).
//  State REPLAY (emit stored rows, newest last):
//   - ready_o=0 (input fully backpressured).
//   - RAM is 1r1w synchronous with 1-cycle read latency.
//   - A read of address col is issued when the output register is empty or being consumed
//     (!valid_o || ready_i) and reads remain in the row group; col/row advance per issued read.
//   - valid_o asserts the cycle after the read is issued.
//   - data_o holds stable while valid_o && !ready_i. Slice r of the RAM word is selected by the row
//     registered alongside the read.
//   - row_o/last_o describe the beat on data_o; last_o high for col LineWidth-1 of each row.
//   - Row order: BufferRows-2 down to 0, LineWidth beats each.
//   - Sustained throughput is 1 beat/cycle when ready_i stays high; no bubbles between rows.
//   - Final beat (row 0, col LineWidth-1) consumed -> PASS.
//   - ready_o may rise the cycle after that handshake, never the same cycle.
//  Boundaries:
//   - col wraps LineWidth-1 -> 0 exactly (non-power-of-2 LineWidth legal).
//   - RAM writes occur only in PASS, reads only in REPLAY (no read/write collision).
//   - valid_i held during REPLAY is neither accepted nor lost.
//   - Reset mid-REPLAY discards remaining stored rows; RAM contents need no clearing.
//   - All width math uses $clog2(LineWidth) counters; no truncation of data slices.
// STRUCTURE
//  - Shared package line_buffer_pkg: state typedef enum logic {PASS, REPLAY} and
//    helper localparam RowIdxWidth = $clog2(BufferRows)+1.
//  - Reuse counter_roll for the column counter (max_val LineWidth-1).
//  - Reuse ram_1r1w_sync: Width = InputChannels*BufferWidth*(BufferRows-1), Depth = LineWidth.
//  - Generate-out the RAM and REPLAY path when BufferRows==1.
//  - No new sub-module; the FSM and replay output register live here (target ~200 lines).
// TESTING
//  1 Defaults, ch0 column c = {r1=8'h10+c, r0=8'h20+c}, c=0..7, ready_i=1 ->
//    out 10..17 (row_o=1, last_o on 17), then 20..27 (row_o=0, last_o on 27);
//    ready_o low for exactly the 8 replay cycles + 1.
//  2 BufferRows=3, LineWidth=5, InputChannels=2 -> 15 beats per group, order r2,r1,r0;
//    channels independent; second back-to-back group identical.
//  3 Random ready_i (50%) during REPLAY -> data_o/row_o/last_o stable while stalled; no beat dropped or duplicated.
//  4 valid_i held high through REPLAY with changing data -> no extra input accepted;
//    first accept occurs in the cycle after the final replay handshake.
//  5 Assert rst_ni low mid-REPLAY (row 0, col 3) -> valid_o=0, ready_o=0 immediately;
//    after release the next group streams correctly from col 0.
//  6 BufferRows=1 -> data_o==data_i, valid_o==valid_i, ready_o==ready_i every cycle;
//    last_o every LineWidth accepted beats.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line-buffer family: the serializer state type and a
// helper that sizes row-index ports from a row count.
package line_buffer_pkg;

  typedef enum logic {PASS, REPLAY} lb_state_e;

  // Row indices carry one spare bit so BufferRows==1 still yields a legal 1-bit port.
  function automatic int row_idx_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// Free-running up counter that rolls over to zero after max_val_i; wrap_o flags the
// enabled cycle on which the rollover happens.
module counter_roll #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] max_val_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == max_val_i);
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == max_val_i) ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one write port, one read port, read data registered one
// cycle after re_i and held until the next read.
module ram_1r1w_sync #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage is never reset; every location is written before it is read back.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_row_serializer.sv
// Turns column beats of stacked rows back into a raster pixel stream: the oldest row
// streams through live, the younger rows are parked in RAM and replayed afterwards.
module multi_row_serializer
  import line_buffer_pkg::*;
#(
  parameter int BufferWidth   = 8,
  parameter int LineWidth     = 8,
  parameter int BufferRows    = 2,
  parameter int InputChannels = 1
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic [InputChannels-1:0][BufferRows-1:0][BufferWidth-1:0] data_i,
  input  logic                                                   valid_i,
  output logic                                                   ready_o,
  output logic [InputChannels-1:0][BufferWidth-1:0]              data_o,
  output logic                                                   valid_o,
  input  logic                                                   ready_i,
  output logic [row_idx_width(BufferRows)-1:0]                   row_o,
  output logic                                                   last_o
);

  localparam int ColWidth    = $clog2(LineWidth);
  localparam int RowIdxWidth = row_idx_width(BufferRows);
  localparam int StoredRows  = (BufferRows > 1) ? BufferRows - 1 : 1;
  localparam int RamWidth    = InputChannels * BufferWidth * StoredRows;

  localparam logic [ColWidth-1:0]    LastCol = ColWidth'(LineWidth - 1);
  localparam logic [RowIdxWidth-1:0] TopRow  = RowIdxWidth'(BufferRows - 1);

  lb_state_e                state_q;
  logic [RowIdxWidth-1:0]   row_q;
  logic                     readsDone_q;
  logic                     outValid_q;
  logic [RowIdxWidth-1:0]   outRow_q;
  logic                     outLast_q;
  logic                     live_q;

  logic [ColWidth-1:0]      col;
  logic                     colWrap;
  logic                     colEn;
  logic                     inFire;
  logic                     replayIssue;
  logic                     finalFire;
  logic [InputChannels-1:0][BufferWidth-1:0] replayData;

  assign inFire      = valid_i && ready_o;
  assign replayIssue = (state_q == REPLAY) && !readsDone_q && (!outValid_q || ready_i);
  assign finalFire   = (state_q == REPLAY) && outValid_q && ready_i && outLast_q && (outRow_q == '0);
  assign colEn       = (state_q == PASS) ? inFire : replayIssue;

  counter_roll #(
    .Width (ColWidth)
  ) u_col (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (colEn),
    .max_val_i (LastCol),
    .count_o   (col),
    .wrap_o    (colWrap)
  );

  // One FSM owns the row cursor and the replay output register; a read issued this
  // cycle becomes the visible beat next cycle, tagged with the row it was read for.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PASS;
      row_q       <= TopRow;
      readsDone_q <= 1'b0;
      outValid_q  <= 1'b0;
      outRow_q    <= TopRow;
      outLast_q   <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        PASS: begin
          if (inFire && colWrap && (BufferRows > 1)) begin
            state_q <= REPLAY;
            row_q   <= TopRow - RowIdxWidth'(1);
          end
        end
        REPLAY: begin
          if (replayIssue) begin
            outValid_q <= 1'b1;
            outRow_q   <= row_q;
            outLast_q  <= (col == LastCol);
            if (col == LastCol) begin
              if (row_q == '0) begin
                readsDone_q <= 1'b1;
              end else begin
                row_q <= row_q - RowIdxWidth'(1);
              end
            end
          end else if (ready_i) begin
            outValid_q <= 1'b0;
          end
          if (finalFire) begin
            state_q     <= PASS;
            row_q       <= TopRow;
            readsDone_q <= 1'b0;
            outValid_q  <= 1'b0;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

  generate
    if (BufferRows > 1) begin : g_replay
      logic [RamWidth-1:0] ramWdata;
      logic [RamWidth-1:0] ramRdata;

      always_comb begin
        ramWdata = '0;
        for (int ch = 0; ch < InputChannels; ch++) begin
          for (int r = 0; r < StoredRows; r++) begin
            ramWdata[(ch*StoredRows + r)*BufferWidth +: BufferWidth] = data_i[ch][r];
          end
        end
      end

      ram_1r1w_sync #(
        .Width (RamWidth),
        .Depth (LineWidth)
      ) u_ram (
        .clk_i   (clk_i),
        .we_i    ((state_q == PASS) && inFire),
        .waddr_i (col),
        .wdata_i (ramWdata),
        .re_i    (replayIssue),
        .raddr_i (col),
        .rdata_o (ramRdata)
      );

      // RAM data only changes on a read, so the selected slice holds through stalls.
      always_comb begin
        replayData = '0;
        for (int ch = 0; ch < InputChannels; ch++) begin
          for (int r = 0; r < StoredRows; r++) begin
            if (outRow_q == RowIdxWidth'(r)) begin
              replayData[ch] = ramRdata[(ch*StoredRows + r)*BufferWidth +: BufferWidth];
            end
          end
        end
      end
    end else begin : g_pass
      assign replayData = '0;
    end
  endgenerate

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    row_o   = TopRow;
    data_o  = '0;
    if (state_q == PASS) begin
      if (live_q) begin
        ready_o = ready_i;
        valid_o = valid_i;
        last_o  = valid_i && (col == LastCol);
        for (int ch = 0; ch < InputChannels; ch++) begin
          data_o[ch] = data_i[ch][BufferRows-1];
        end
      end
    end else begin
      valid_o = outValid_q;
      row_o   = outRow_q;
      last_o  = outValid_q && outLast_q;
      data_o  = replayData;
    end
  end

endmodule

// File: tb/tb_multi_row_serializer.sv
// Directed bench for multi_row_serializer: default config, a 3-row 2-channel config
// and the single-row pass-through config, sharing one clock and reset.
module tb_multi_row_serializer;

  logic clk;
  logic rst_n;

  int vecCount = 0;
  int errCount = 0;

  // Config A: defaults (8-bit, 8 columns, 2 rows, 1 channel)
  logic [0:0][1:0][7:0] aDataI;
  logic [0:0][7:0]      aDataO;
  logic                 aValidI, aReadyO, aValidO, aReadyI, aLastO;
  logic [1:0]           aRowO;

  // Config B: 3 rows, 5 columns, 2 channels
  logic [1:0][2:0][7:0] bDataI;
  logic [1:0][7:0]      bDataO;
  logic                 bValidI, bReadyO, bValidO, bReadyI, bLastO;
  logic [2:0]           bRowO;

  // Config C: single row pass-through, 4 columns
  logic [0:0][0:0][7:0] cDataI;
  logic [0:0][7:0]      cDataO;
  logic                 cValidI, cReadyO, cValidO, cReadyI, cLastO;
  logic [0:0]           cRowO;

  multi_row_serializer dutA (
    .clk_i(clk), .rst_ni(rst_n), .data_i(aDataI), .valid_i(aValidI), .ready_o(aReadyO),
    .data_o(aDataO), .valid_o(aValidO), .ready_i(aReadyI), .row_o(aRowO), .last_o(aLastO)
  );

  multi_row_serializer #(.BufferWidth(8), .LineWidth(5), .BufferRows(3), .InputChannels(2)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .data_i(bDataI), .valid_i(bValidI), .ready_o(bReadyO),
    .data_o(bDataO), .valid_o(bValidO), .ready_i(bReadyI), .row_o(bRowO), .last_o(bLastO)
  );

  multi_row_serializer #(.BufferWidth(8), .LineWidth(4), .BufferRows(1), .InputChannels(1)) dutC (
    .clk_i(clk), .rst_ni(rst_n), .data_i(cDataI), .valid_i(cValidI), .ready_o(cReadyO),
    .data_o(cDataO), .valid_o(cValidO), .ready_i(cReadyI), .row_o(cRowO), .last_o(cLastO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Feed columns startC..7 of a group into A; the oldest row must appear live.
  task automatic applyStimulusA(input logic [7:0] b1, input logic [7:0] b0, input int startC);
    for (int c = startC; c < 8; c++) begin
      @(posedge clk); #1;
      aDataI[0][1] = b1 + 8'(c);
      aDataI[0][0] = b0 + 8'(c);
      aValidI = 1'b1;
      aReadyI = 1'b1;
      @(negedge clk);
      checkOutput("A live data", aDataO[0], b1 + 8'(c));
      checkOutput("A live row", aRowO, 1);
      checkOutput("A live last", aLastO, c == 7);
      checkOutput("A live ready", aReadyO, 1);
    end
  endtask

  // Watch A's replay; any visible beat must be the next expected one, stalled or not.
  task automatic replayA(input logic [7:0] b0, input bit randReady, input bit holdValid, input int stopAt,
                         output int lowCnt, output int beats, output int brkCyc);
    lowCnt = 0;
    beats  = 0;
    brkCyc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      aReadyI = (randReady && beats < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      aValidI = holdValid;
      aDataI[0][1] = 8'hA0 + 8'(cyc);
      aDataI[0][0] = 8'hB0 + 8'(cyc);
      @(negedge clk);
      if (aReadyO) begin
        brkCyc = cyc;
        break;
      end
      lowCnt++;
      if (stopAt >= 0 && beats == stopAt && aValidO) begin
        brkCyc = cyc;
        return;
      end
      if (aValidO) begin
        checkOutput("A replay data", aDataO[0], b0 + 8'(beats));
        checkOutput("A replay row", aRowO, 0);
        checkOutput("A replay last", aLastO, beats == 7);
        if (aReadyI) beats++;
      end
    end
  endtask

  function automatic logic [7:0] valB(input int g, input int h, input int r, input int c);
    return 8'(g*128 + h*64 + r*16 + c);
  endfunction

  task automatic driveB(input int g, input int c);
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 3; r++)
        bDataI[h][r] = valB(g, h, r, c);
  endtask

  task automatic applyStimulusB(input int g, input int startC);
    for (int c = startC; c < 5; c++) begin
      @(posedge clk); #1;
      driveB(g, c);
      bValidI = 1'b1;
      bReadyI = 1'b1;
      @(negedge clk);
      for (int h = 0; h < 2; h++) checkOutput("B live data", bDataO[h], valB(g, h, 2, c));
      checkOutput("B live row", bRowO, 2);
      checkOutput("B live last", bLastO, c == 4);
      checkOutput("B live ready", bReadyO, 1);
    end
  endtask

  task automatic replayB(input int g, input bit preload, output int beats, output int brkCyc);
    int r;
    int c;
    beats  = 0;
    brkCyc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      bReadyI = 1'b1;
      bValidI = preload;
      driveB(g + 1, 0);
      @(negedge clk);
      if (bReadyO) begin
        brkCyc = cyc;
        break;
      end
      if (bValidO) begin
        r = 1 - beats / 5;
        c = beats % 5;
        for (int h = 0; h < 2; h++) checkOutput("B replay data", bDataO[h], valB(g, h, r, c));
        checkOutput("B replay row", bRowO, r);
        checkOutput("B replay last", bLastO, c == 4);
        beats++;
      end
    end
  endtask

  initial begin
    int lowCnt, beats, brk, k, acc;
    aDataI = 16'h5566; aValidI = 1'b1; aReadyI = 1'b1;
    bDataI = '0; bValidI = 1'b0; bReadyI = 1'b0;
    cDataI = '0; cValidI = 1'b0; cReadyI = 1'b0;
    rst_n = 1'b0;

    // Reset state of A with traffic offered on both sides
    @(negedge clk);
    checkOutput("A reset ready", aReadyO, 0);
    checkOutput("A reset valid", aValidO, 0);
    checkOutput("A reset last", aLastO, 0);
    checkOutput("A reset row", aRowO, 1);
    checkOutput("A reset data", aDataO[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    aValidI = 1'b0;

    $display("[TB] basic two-row group");
    applyStimulusA(8'h10, 8'h20, 0);
    replayA(8'h20, 1'b0, 1'b0, -1, lowCnt, beats, brk);
    checkOutput("A1 replay beats", beats, 8);
    checkOutput("A1 ready low cycles", lowCnt, 9);

    $display("[TB] random downstream stalls");
    applyStimulusA(8'h40, 8'h50, 0);
    replayA(8'h50, 1'b1, 1'b0, -1, lowCnt, beats, brk);
    checkOutput("A3 replay beats", beats, 8);
    checkOutput("A3 reached end", brk >= 0, 1);

    $display("[TB] input held valid through replay");
    applyStimulusA(8'h60, 8'h70, 0);
    replayA(8'h70, 1'b0, 1'b1, -1, lowCnt, beats, brk);
    checkOutput("A4 replay beats", beats, 8);
    checkOutput("A4 ready low cycles", lowCnt, 9);
    checkOutput("A4 first accept valid", aValidO, 1);
    checkOutput("A4 first accept data", aDataO[0], 8'hA0 + 8'(brk));
    k = brk;

    $display("[TB] reset during replay");
    applyStimulusA(8'hA0 + 8'(k), 8'hB0 + 8'(k), 1);
    replayA(8'hB0 + 8'(k), 1'b0, 1'b0, 3, lowCnt, beats, brk);
    checkOutput("A5 stop point", beats, 3);
    checkOutput("A5 stop col3 data", aDataO[0], 8'hB3 + 8'(k));
    rst_n = 1'b0;
    #1;
    checkOutput("A5 reset valid", aValidO, 0);
    checkOutput("A5 reset ready", aReadyO, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    aValidI = 1'b0;
    applyStimulusA(8'hC0, 8'hD0, 0);
    replayA(8'hD0, 1'b0, 1'b0, -1, lowCnt, beats, brk);
    checkOutput("A5 post-reset beats", beats, 8);
    checkOutput("A5 post-reset low cycles", lowCnt, 9);

    $display("[TB] three rows, two channels, back-to-back groups");
    applyStimulusB(0, 0);
    replayB(0, 1'b1, beats, brk);
    checkOutput("B group0 beats", beats, 10);
    checkOutput("B next live valid", bValidO, 1);
    for (int h = 0; h < 2; h++) checkOutput("B next live data", bDataO[h], valB(1, h, 2, 0));
    applyStimulusB(1, 1);
    replayB(1, 1'b0, beats, brk);
    checkOutput("B group1 beats", beats, 10);
    checkOutput("B group1 reached end", brk >= 0, 1);

    $display("[TB] single-row pass-through");
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      cValidI = 1'($urandom_range(0, 1));
      cReadyI = 1'($urandom_range(0, 1));
      cDataI[0][0] = 8'($urandom);
      @(negedge clk);
      checkOutput("C data", cDataO[0], cDataI[0][0]);
      checkOutput("C valid", cValidO, cValidI);
      checkOutput("C ready", cReadyO, cReadyI);
      checkOutput("C row", cRowO, 0);
      checkOutput("C last", cLastO, cValidI && (acc % 4 == 3));
      if (cValidI && cReadyI) acc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
